// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types, default sizes and round-robin pointer helper for reg_bank_arbiter.
// Pure declarations: no latency, no backpressure.
package reg_bank_arbiter_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 2;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Pointer after serving index cur: one past the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester write bus plus read port of the shared register bank.
// Level req held until a one-cycle ack; read port is combinational.
interface reg_bank_arbiter_if
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*ADDR_WIDTH-1:0] wr_addr;
    logic [N_REQ*DATA_WIDTH-1:0] wr_data;
    logic [N_REQ-1:0]            ack;
    logic                        busy;
    logic [GW-1:0]               grant_id;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [DATA_WIDTH-1:0]       rd_data;

    modport master (
        output req, wr_addr, wr_data, rd_addr,
        input  ack, busy, grant_id, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, rd_addr,
        output ack, busy, grant_id, rd_data
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
// Zero latency; no backpressure (valid is simply any request present).
module rr_pick #(
    parameter int N  = 4,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          valid,
    output logic [GW-1:0] winner
);

    int          s;
    logic [GW-1:0] idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        winner = '0;
        s      = 0;
        idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            idx = GW'(s);
            if (req[idx]) winner = idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated writes into a small register bank; grant edge then commit edge.
// One write per two cycles; losers hold req with ack low until served.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    reg_bank_arbiter_if.slave  bus
);

    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREG = 1 << ADDR_WIDTH;

    state_t                 state_q, state_d;
    logic [GW-1:0]          ptr_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          winner;
    logic                   win_vld;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  bank_q [NREG];
    logic [NREG-1:0]        ld_en;

    rr_pick #(
        .N  (N_REQ),
        .GW (GW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .valid  (win_vld),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == WRITE);
        bus.ack  = '0;
        if (state_q == WRITE) bus.ack[grant_q] = 1'b1;
    end

    assign bus.grant_id = grant_q;

    // Address/data are snapshotted at the grant so the requester may change them during WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (state_q == IDLE && win_vld) begin
            grant_q <= winner;
            addr_q  <= bus.wr_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            data_q  <= bus.wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        end else if (state_q == WRITE) begin
            ptr_q <= GW'(rr_next(32'(grant_q), N_REQ));
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_bank
        assign ld_en[r] = (state_q == WRITE) && (addr_q == ADDR_WIDTH'(r));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)          bank_q[r] <= '0;
            else if (ld_en[r]) bank_q[r] <= data_q;
        end
    end

    // No write bypass: a read of the address being committed sees the old value.
    assign bus.rd_data = bank_q[bus.rd_addr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and random bench for reg_bank_arbiter against a cycle-level reference model.
module tb_reg_bank_arbiter;

    localparam int N    = 4;
    localparam int DW   = 2;
    localparam int AW   = 2;
    localparam int NREG = 1 << AW;

    logic clk;
    logic rst;

    reg_bank_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_bank_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents, rotation pointer, and an in-flight grant.
    int mbank [NREG];
    int mptr, mw, maddr, mdata, mgrant;
    bit mphase;
    bit auto_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mbank[i] = 0;
        mptr = 0; mw = 0; maddr = 0; mdata = 0; mgrant = 0; mphase = 0;
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (mphase) begin
            mbank[maddr] = mdata;
            mptr   = (mw + 1) % N;
            mphase = 0;
        end else begin
            w = pick(bus.req);
            if (w >= 0) begin
                mw     = w;
                mgrant = w;
                maddr  = int'(bus.wr_addr[w*AW +: AW]);
                mdata  = int'(bus.wr_data[w*DW +: DW]);
                mphase = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_ack;
        exp_ack = '0;
        if (mphase) exp_ack[mw] = 1'b1;
        chk({tag, "_ack"},   32'(bus.ack),      32'(exp_ack));
        chk({tag, "_busy"},  32'(bus.busy),     32'(mphase));
        chk({tag, "_grant"}, 32'(bus.grant_id), 32'(mgrant));
        chk({tag, "_rd"},    32'(bus.rd_data),  32'(mbank[int'(bus.rd_addr)]));
    endtask

    // One clock: advance the model on the edge the DUT sees, then compare 1 ns later.
    task automatic step(input string tag);
        int drop;
        drop = -1;
        if (rst) begin
            if (mphase && auto_drop) drop = mw;
            model_edge();
        end
        @(posedge clk);
        #1;
        if (drop >= 0) bus.req[drop] = 1'b0;
        check_outputs(tag);
    endtask

    task automatic set_req(input int i, input int a, input int d);
        bus.wr_addr[i*AW +: AW] = AW'(a);
        bus.wr_data[i*DW +: DW] = DW'(d);
        bus.req[i] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step("rst");
        rst = 1'b1;
    endtask

    int n02;
    int gseq [4] = '{1, 3, 1, 3};

    initial begin
        rst = 1'b0;
        bus.req = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        auto_drop = 1'b1;
        model_reset();

        repeat (2) step("reset");
        for (int a = 0; a < NREG; a++) begin
            bus.rd_addr = AW'(a); #1;
            chk("reset_bank", 32'(bus.rd_data), 32'd0);
        end
        rst = 1'b1;

        // Single request: ack in the second cycle, data visible in the third.
        set_req(0, 2, 3);
        step("single_grant");
        chk("single_ack", 32'(bus.ack), 32'b0001);
        step("single_commit");
        chk("single_ack_off", 32'(bus.ack), 32'd0);
        for (int a = 0; a < NREG; a++) begin
            bus.rd_addr = AW'(a); #1;
            chk("single_bank", 32'(bus.rd_data), (a == 2) ? 32'd3 : 32'd0);
        end

        // All four held from ptr 0: served in order, every other cycle.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, i, i);
        for (int i = 0; i < N; i++) begin
            step("all4_grant");
            chk("all4_gid", 32'(bus.grant_id), 32'(i));
            chk("all4_ack", 32'(bus.ack), 32'(1 << i));
            step("all4_commit");
        end
        for (int a = 0; a < NREG; a++) begin
            bus.rd_addr = AW'(a); #1;
            chk("all4_bank", 32'(bus.rd_data), 32'(a));
        end

        // Continuous 1010: strict alternation, 0 and 2 never acked.
        auto_drop = 1'b0;
        bus.req = 4'b1010;
        n02 = 0;
        for (int k = 0; k < 4; k++) begin
            step("rot_grant");
            chk("rot_gid", 32'(bus.grant_id), 32'(gseq[k]));
            n02 += int'(bus.ack[0]) + int'(bus.ack[2]);
            step("rot_commit");
            n02 += int'(bus.ack[0]) + int'(bus.ack[2]);
        end
        bus.req = '0;
        auto_drop = 1'b1;
        step("rot_idle");
        chk("rot_starved_acks", 32'(n02), 32'd0);

        // Requester 2 changes data and drops req during WRITE; commit is unaffected.
        set_req(2, 1, 2);
        step("drop_grant");
        chk("drop_ack", 32'(bus.ack), 32'b0100);
        bus.wr_data[2*DW +: DW] = '0;
        bus.req[2] = 1'b0;
        step("drop_commit");
        bus.rd_addr = AW'(1); #1;
        chk("drop_bank", 32'(bus.rd_data), 32'd2);

        // Read-during-write returns the old value.
        set_req(0, 3, 2);
        step("rdw_g0"); step("rdw_c0");
        set_req(1, 3, 1);
        bus.rd_addr = AW'(3);
        step("rdw_grant");
        chk("rdw_old", 32'(bus.rd_data), 32'd2);
        step("rdw_commit");
        chk("rdw_new", 32'(bus.rd_data), 32'd1);

        // Reset pulled during WRITE: no ack, bank cleared, re-arbitration from 0.
        set_req(3, 2, 3);
        step("mid_grant");
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0; #1;
        chk("mid_ack",  32'(bus.ack),     32'd0);
        chk("mid_busy", 32'(bus.busy),    32'd0);
        chk("mid_rd",   32'(bus.rd_data), 32'd0);
        model_reset();
        step("mid_hold"); step("mid_hold");
        rst = 1'b1;
        step("mid_regrant");
        chk("mid_gid", 32'(bus.grant_id), 32'd3);
        chk("mid_ack2", 32'(bus.ack), 32'b1000);
        step("mid_commit");
        bus.rd_addr = AW'(2); #1;
        chk("mid_bank", 32'(bus.rd_data), 32'd3);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!bus.req[i] && $urandom_range(3) == 0)
                    set_req(i, int'($urandom_range(NREG - 1)), int'($urandom_range((1 << DW) - 1)));
            bus.rd_addr = AW'($urandom_range(NREG - 1));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
